stream_mux_nto1: RTL and testbench
==================================

// Module: stream_mux_nto1
// PURPOSE
//   Parametrised N:1 streaming multiplexer: successor to the combinational 2:1 mux.
//   Selects one of N valid/ready input channels, either by a fixed select port or by
//   round-robin arbitration, and registers the chosen beat into a 1-entry output stage.
//   Sits between multiple producers and one shared downstream consumer.
// PARAMETERS
//   N      4   number of input channels (>=2)
//   WIDTH  8   data width per channel
//   SELW   $clog2(N)   select/channel-index width (derived, not overridden)
// PORTS
//   clk        in   1          single clock; all state updates on rising edge
//   rst        in   1          synchronous, active-high reset
//   mode       in   1          0 = fixed select (sel), 1 = round-robin
//   sel        in   SELW       channel index used when mode=0
//   in_valid   in   N          per-channel valid
//   in_data    in   N*WIDTH    channel i data at [i*WIDTH +: WIDTH]
//   in_ready   out  N          per-channel ready (combinational from state + inputs)
//   out_valid  out  1          output register holds a beat
//   out_data   out  WIDTH      registered data
//   out_ch     out  SELW       index of channel that produced out_data
//   out_ready  in   1          downstream accepts beat when out_valid & out_ready
// BEHAVIOUR
//   - Reset: out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready=0 while rst=1.
//     Reset mid-operation discards any held beat; no input is consumed that cycle.
//   - can_load = !out_valid | out_ready (empty, or draining this cycle).
//   - Grant (combinational): mode=0: grant=sel if sel<N and in_valid[sel], else none.
//     sel>=N -> no grant, all in_ready=0. mode=1: first i with in_valid[i], searching
//     rr_ptr, rr_ptr+1, ... wrapping modulo N; none if in_valid==0.
//   - in_ready[i] = can_load & granted & (grant==i); at most one bit set per cycle.
//   - Transfer in: when in_valid[g] & in_ready[g]: next cycle out_valid=1,
//     out_data=in_data[g], out_ch=g. Latency exactly 1 cycle input->output.
//   - Transfer out without refill: out_valid clears next cycle.
//   - Simultaneous drain + load: out_valid stays 1, new beat replaces old; full
//     throughput of 1 beat/cycle, no bubble.
//   - Stall (out_valid & !out_ready): out_data/out_ch held stable; all in_ready=0.
//   - rr_ptr updates only on an accepted beat in mode=1: rr_ptr = (g+1) mod N
//     (g=N-1 wraps to 0). Unchanged in mode=0 and on cycles with no transfer.
//   - mode/sel changes take effect on the next grant; held beat is never altered.
//   - Unused in_valid bits with in_ready=0 are ignored; no beat is ever duplicated
//     or dropped once accepted.
// STRUCTURE
//   - Package stream_mux_pkg: clog2 helper function, typedef for mode encoding
//     (MODE_FIXED=1'b0, MODE_RR=1'b1).
//   - One sub-module: rr_arbiter (N, inputs req[N], ptr; outputs gnt_idx, gnt_vld),
//     purely combinational rotate-priority encoder; top holds ptr and output register.
// TESTING
//   - Reset: assert rst 2 cycles with all in_valid=1 -> out_valid=0, out_data=0,
//     out_ch=0, in_ready=0000 throughout.
//   - Fixed select: mode=0, sel=2, in_data ch2=8'hA5, in_valid=0100, out_ready=1 ->
//     in_ready=0100; next cycle out_valid=1, out_data=A5, out_ch=2.
//   - Invalid/idle select: mode=0, sel=1, in_valid=1101 -> in_ready=0000, out_valid
//     stays 0; N=3 build with sel=3 -> no grant.
//   - Round-robin fairness: mode=1, in_valid=1111 constant, out_ready=1, ch i data=i
//     -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles, no bubbles.
//   - Backpressure: out_valid=1 (data 8'h11), out_ready=0 for 3 cycles with ch1 valid
//     -> out_data holds 11, in_ready=0000; on out_ready=1 the ch1 beat appears next cycle.
//   - Reset mid-stream: rst pulse while out_valid=1 -> out_valid=0 next cycle, held
//     beat lost, rr_ptr=0 (next RR grant with in_valid=1010 is ch1).
//   - Random: 1000 cycles random valid/ready/mode/sel vs. scoreboard model; check no
//     loss/duplication, ordering per channel, one-hot-or-zero in_ready.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the N:1 streaming multiplexer: mode encoding and
// a constant-function log2 used to size channel-index ports.
package stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Ceiling log2, never below 1 so a 2-channel mux still gets a 1-bit index.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// Rotate-priority encoder: returns the first requesting channel found when
// searching from ptr upward, wrapping modulo N. Purely combinational; the
// pointer itself lives in the parent so it only moves on accepted beats.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_vld
);

    int cand;

    // Walk the N candidates in priority order starting at ptr; first hit wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!gnt_vld && req[cand[SELW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[SELW-1:0];
            end
        end
    end

endmodule

// File: rtl/stream_mux_nto1.sv
// N:1 valid/ready stream multiplexer with a 1-entry registered output stage.
// Channel choice is either a fixed select index or round-robin arbitration;
// the output register refills in the same cycle it drains, so a continuously
// ready consumer sees one beat per cycle.
module stream_mux_nto1
    import stream_mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 8,
    localparam int SELW  = clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_ch,
    input  logic               out_ready
);

    // Valid vector padded to the full index range so an out-of-range select
    // lands on a zero bit and simply produces no grant.
    localparam int NPOW = 1 << SELW;

    logic [SELW-1:0]  rr_ptr;
    logic [SELW-1:0]  ptr_next;
    logic [SELW-1:0]  rr_idx;
    logic             rr_vld;
    logic [SELW-1:0]  grant_idx;
    logic             grant_vld;
    logic [NPOW-1:0]  valid_ext;
    logic [WIDTH-1:0] ch_data [N];
    logic             can_load;
    logic             take;

    rr_arbiter #(
        .N (N)
    ) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    // Unpack the flat data bus into one word per channel.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            ch_data[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Select the grant source for the current mode.
    always_comb begin
        valid_ext          = '0;
        valid_ext[N-1:0]   = in_valid;
        grant_idx          = '0;
        grant_vld          = 1'b0;
        if (mode == MODE_RR) begin
            grant_idx = rr_idx;
            grant_vld = rr_vld;
        end else begin
            grant_idx = sel;
            grant_vld = valid_ext[sel];
        end
    end

    assign can_load = !out_valid || out_ready;

    // Ready goes only to the granted channel, and only when the output stage
    // can take a beat this cycle; reset forces every ready low.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = !rst && can_load && grant_vld && (grant_idx == SELW'(i));
        end
    end

    assign take     = |(in_valid & in_ready);
    assign ptr_next = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;

    // Output stage: load on an accepted input beat (replacing any draining
    // beat), clear on a drain with no refill, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else begin
            if (take) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[grant_idx];
                out_ch    <= grant_idx;
                if (mode == MODE_RR) begin
                    rr_ptr <= ptr_next;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Directed plus randomized bench for stream_mux_nto1, with a behavioural
// reference model and an in-order beat scoreboard.
module tb_stream_mux_nto1;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         mode;
    logic [1:0]   sel;
    logic [3:0]   in_valid;
    logic [7:0]   chd [4];
    logic [31:0]  in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [7:0]   out_data;
    logic [1:0]   out_ch;
    logic         out_ready;

    logic         rst3;
    logic         mode3;
    logic [1:0]   sel3;
    logic [2:0]   in_valid3;
    logic [23:0]  in_data3;
    logic [2:0]   in_ready3;
    logic         out_valid3;
    logic [7:0]   out_data3;
    logic [1:0]   out_ch3;
    logic         out_ready3;

    int checks   = 0;
    int failures = 0;

    logic         m_valid = 1'b0;
    logic [7:0]   m_data  = 8'h00;
    logic [1:0]   m_ch    = 2'd0;
    int           m_ptr   = 0;
    logic [9:0]   sbq [$];

    always #5 clk = ~clk;

    assign in_data = {chd[3], chd[2], chd[1], chd[0]};

    stream_mux_nto1 #(.N(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    stream_mux_nto1 #(.N(3), .WIDTH(8)) dut3 (
        .clk       (clk),
        .rst       (rst3),
        .mode      (mode3),
        .sel       (sel3),
        .in_valid  (in_valid3),
        .in_data   (in_data3),
        .in_ready  (in_ready3),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .out_ch    (out_ch3),
        .out_ready (out_ready3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // One clock cycle: inputs are already driven just after a falling edge.
    // Checks ready against the model, scores any drain, advances the model
    // at the rising edge, then checks the registered outputs.
    task automatic step(input string tag);
        logic       gv;
        int         g;
        logic [3:0] er;
        logic [9:0] front;
        #1;
        gv = 1'b0;
        g  = 0;
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) begin
                gv = 1'b1;
                g  = int'(sel);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (!gv && in_valid[i[1:0]]) begin
                    gv = 1'b1;
                    g  = i;
                end
            end
        end
        er = (!rst && (!m_valid || out_ready) && gv) ? 4'(1 << g) : 4'b0000;
        chk({tag, ":in_ready"}, 32'(in_ready), 32'(er));
        chk({tag, ":onehot"}, 32'($countones(in_ready) <= 1), 32'd1);
        if (!rst && out_valid === 1'b1 && out_ready) begin
            chk({tag, ":sb_depth"}, sbq.size(), 32'd1);
            if (sbq.size() > 0) begin
                front = sbq.pop_front();
                chk({tag, ":sb_beat"}, 32'({out_ch, out_data}), 32'(front));
            end
        end
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_ch    = 2'd0;
            m_ptr   = 0;
            sbq.delete();
        end else if (er != 4'b0000 && in_valid[g[1:0]]) begin
            m_valid = 1'b1;
            m_data  = chd[g[1:0]];
            m_ch    = g[1:0];
            if (mode) m_ptr = (g + 1) % N;
            sbq.push_back({g[1:0], chd[g[1:0]]});
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        chk({tag, ":out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ":out_data"}, 32'(out_data), 32'(m_data));
        chk({tag, ":out_ch"}, 32'(out_ch), 32'(m_ch));
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) chd[i] = 8'h00;
        rst3 = 1'b1; mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000;
        in_data3 = 24'h0; out_ready3 = 1'b1;
        @(negedge clk);

        // Reset held two cycles with every channel valid.
        step("rst0");
        step("rst1");

        // Three-channel build: an out-of-range select grants nothing.
        rst3 = 1'b0; mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
        in_data3 = 24'h3C2211;
        #1;
        chk("n3_sel3_ready", 32'(in_ready3), 32'd0);
        @(negedge clk);
        chk("n3_sel3_valid", 32'(out_valid3), 32'd0);
        sel3 = 2'd2;
        #1;
        chk("n3_sel2_ready", 32'(in_ready3), 32'b100);
        @(negedge clk);
        chk("n3_sel2_valid", 32'(out_valid3), 32'd1);
        chk("n3_sel2_data", 32'(out_data3), 32'h3C);
        chk("n3_sel2_ch", 32'(out_ch3), 32'd2);
        step("rst2");

        // Fixed select of channel 2.
        rst = 1'b0; mode = 1'b0; sel = 2'd2; chd[2] = 8'hA5; in_valid = 4'b0100;
        step("fixed");
        chk("fixed_valid", 32'(out_valid), 32'd1);
        chk("fixed_data", 32'(out_data), 32'hA5);
        chk("fixed_ch", 32'(out_ch), 32'd2);

        in_valid = 4'b0000;
        step("drain");
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Selected channel idle while others are valid.
        sel = 2'd1; in_valid = 4'b1101;
        step("sel_idle");
        chk("sel_idle_valid", 32'(out_valid), 32'd0);

        // Round-robin with all channels valid: 0,1,2,3,0,1 with no bubbles.
        mode = 1'b1; in_valid = 4'hF;
        for (int i = 0; i < 4; i++) chd[i] = 8'(i);
        for (int k = 0; k < 6; k++) begin
            step("rr");
            chk("rr_valid", 32'(out_valid), 32'd1);
            chk("rr_seq_ch", 32'(out_ch), 32'(k % 4));
        end

        // Backpressure: hold 0x11 for three stalled cycles, then ch1 follows.
        mode = 1'b0; sel = 2'd0; chd[0] = 8'h11; in_valid = 4'b0001; out_ready = 1'b1;
        step("bp_load");
        chk("bp_load_data", 32'(out_data), 32'h11);
        out_ready = 1'b0; sel = 2'd1; chd[1] = 8'h22; in_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step("bp_stall");
            chk("bp_hold_data", 32'(out_data), 32'h11);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step("bp_release");
        chk("bp_next_data", 32'(out_data), 32'h22);
        chk("bp_next_ch", 32'(out_ch), 32'd1);

        // Reset mid-stream discards the held beat and rewinds the pointer.
        rst = 1'b1; in_valid = 4'hF;
        step("mid_rst");
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0; mode = 1'b1; in_valid = 4'b1010;
        step("post_rst_rr");
        chk("post_rst_ch", 32'(out_ch), 32'd1);

        // Randomized traffic against the model and scoreboard.
        for (int n = 0; n < 1000; n++) begin
            rst       = ($urandom_range(0, 63) == 0);
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) chd[i] = 8'($urandom);
            step("rand");
        end

        rst = 1'b0; in_valid = 4'b0000; out_ready = 1'b1;
        step("flush");
        chk("sb_leftover", sbq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
